aes_cmd_ctrl: RTL



---
 rtl/aes_cmd_ctrl_if.sv | 53 +++++
 rtl/aes_cmd_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_cmd_ctrl_if.sv
// Host/core signal bundle for the AES command controller.
// The slave modport is the controller's view; the master modport is the
// environment (host adapter plus AES core) that drives the controller.
interface aes_cmd_ctrl_if;
    // command channel
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_mode;
    logic         cmd_enc_dec;
    // key/data write stream
    logic         wr_valid;
    logic         wr_ready;
    logic [31:0]  wr_data;
    // result read stream
    logic         rd_valid;
    logic         rd_ready;
    logic [31:0]  rd_data;
    // AES core control
    logic         core_start;
    logic [1:0]   core_mode;
    logic         core_enc_dec;
    logic [3:0]   core_round_amount;
    logic [255:0] core_key;
    logic [127:0] core_block;
    logic         core_done;
    logic [127:0] core_result;
    // status
    logic         busy;
    logic         err_mode;
    logic         err_timeout;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_enc_dec,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  core_done, core_result,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output core_start, core_mode, core_enc_dec, core_round_amount,
        output core_key, core_block,
        output busy, err_mode, err_timeout
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_enc_dec,
        output wr_valid, wr_data,
        output rd_ready,
        output core_done, core_result,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  core_start, core_mode, core_enc_dec, core_round_amount,
        input  core_key, core_block,
        input  busy, err_mode, err_timeout
    );
endinterface

// File: rtl/aes_cmd_ctrl.sv
// Host-side command controller for the AES core: takes a command, streams in
// key and block words, fires a one-cycle start, waits for done under a
// watchdog and streams the 128-bit result back as four 32-bit words.
module aes_cmd_ctrl #(
    parameter int TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           reset_n,
    aes_cmd_ctrl_if.slave  bus
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_KEY, LOAD_DATA, START, BUSY, UNLOAD
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [2:0]     r_word_cnt;
    logic [WDW-1:0] r_wdog;
    logic [255:0]   r_key;
    logic [127:0]   r_block;
    logic [127:0]   r_result;
    logic [1:0]     r_mode;
    logic           r_enc_dec;
    logic [3:0]     r_round;
    logic           r_err_mode;
    logic           r_err_timeout;

    logic           w_cmd_accept;
    logic           w_cmd_illegal;
    logic           w_key_we;
    logic           w_blk_we;
    logic           w_done_take;
    logic           w_wdog_expire;
    logic           w_rd_take;
    logic [2:0]     w_last_key;
    logic [31:0]    w_res_word [4];

    // Index of the final key word for the latched key size (nk - 1).
    always_comb begin
        case (r_mode)
            2'b00:   w_last_key = 3'd3;
            2'b01:   w_last_key = 3'd5;
            default: w_last_key = 3'd7;
        endcase
    end

    // State register; an asynchronous reset always lands in IDLE so no start
    // pulse can follow its release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state decode plus the per-cycle events the datapath acts on.
    always_comb begin
        w_state_next  = r_state;
        w_cmd_accept  = 1'b0;
        w_cmd_illegal = 1'b0;
        w_key_we      = 1'b0;
        w_blk_we      = 1'b0;
        w_done_take   = 1'b0;
        w_wdog_expire = 1'b0;
        w_rd_take     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_mode == 2'b11) begin
                        w_cmd_illegal = 1'b1;
                    end else begin
                        w_cmd_accept = 1'b1;
                        w_state_next = LOAD_KEY;
                    end
                end
            end
            LOAD_KEY: begin
                if (bus.wr_valid) begin
                    w_key_we = 1'b1;
                    if (r_word_cnt == w_last_key) w_state_next = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                if (bus.wr_valid) begin
                    w_blk_we = 1'b1;
                    if (r_word_cnt == 3'd3) w_state_next = START;
                end
            end
            START: w_state_next = BUSY;
            BUSY: begin
                // done takes priority over a watchdog expiring in the same cycle
                if (bus.core_done) begin
                    w_done_take  = 1'b1;
                    w_state_next = UNLOAD;
                end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                    w_wdog_expire = 1'b1;
                    w_state_next  = IDLE;
                end
            end
            UNLOAD: begin
                if (bus.rd_ready) begin
                    w_rd_take = 1'b1;
                    if (r_word_cnt == 3'd3) w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Shared word counter for key load, block load and result unload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_cnt <= '0;
        end else if (w_cmd_accept || w_done_take) begin
            r_word_cnt <= '0;
        end else if (w_key_we) begin
            r_word_cnt <= (r_word_cnt == w_last_key) ? 3'd0 : r_word_cnt + 3'd1;
        end else if (w_blk_we || w_rd_take) begin
            r_word_cnt <= (r_word_cnt == 3'd3) ? 3'd0 : r_word_cnt + 3'd1;
        end
    end

    // Watchdog: cleared while issuing start, counts every BUSY cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               r_wdog <= '0;
        else if (r_state == START)  r_wdog <= '0;
        else if (r_state == BUSY)   r_wdog <= r_wdog + WDW'(1);
    end

    // Operation configuration, latched together when a legal command lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode    <= '0;
            r_enc_dec <= 1'b0;
            r_round   <= '0;
        end else if (w_cmd_accept) begin
            r_mode    <= bus.cmd_mode;
            r_enc_dec <= bus.cmd_enc_dec;
            case (bus.cmd_mode)
                2'b00:   r_round <= 4'd10;
                2'b01:   r_round <= 4'd12;
                default: r_round <= 4'd14;
            endcase
        end
    end

    // Key register, left-justified: word 0 lands in the top 32 bits; the
    // words a shorter key never writes stay at the zero set on command accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key <= '0;
        end else if (w_cmd_accept) begin
            r_key <= '0;
        end else if (w_key_we) begin
            for (int i = 0; i < 8; i++) begin
                if (r_word_cnt == 3'(i)) r_key[255-32*i -: 32] <= bus.wr_data;
            end
        end
    end

    // Input block, most significant word first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_block <= '0;
        end else if (w_blk_we) begin
            for (int i = 0; i < 4; i++) begin
                if (r_word_cnt == 3'(i)) r_block[127-32*i -: 32] <= bus.wr_data;
            end
        end
    end

    // Result capture on the done pulse seen while BUSY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         r_result <= '0;
        else if (w_done_take) r_result <= bus.core_result;
    end

    // Error pulses are registered so they appear the cycle after the event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_mode    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_mode    <= w_cmd_illegal;
            r_err_timeout <= w_wdog_expire;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_res_word
        assign w_res_word[gi] = r_result[127-32*gi -: 32];
    end

    assign bus.cmd_ready         = (r_state == IDLE);
    assign bus.wr_ready          = (r_state == LOAD_KEY) || (r_state == LOAD_DATA);
    assign bus.rd_valid          = (r_state == UNLOAD);
    assign bus.rd_data           = (r_state == UNLOAD) ? w_res_word[r_word_cnt[1:0]] : 32'd0;
    assign bus.core_start        = (r_state == START);
    assign bus.busy              = (r_state != IDLE);
    assign bus.core_mode         = r_mode;
    assign bus.core_enc_dec      = r_enc_dec;
    assign bus.core_round_amount = r_round;
    assign bus.core_key          = r_key;
    assign bus.core_block        = r_block;
    assign bus.err_mode          = r_err_mode;
    assign bus.err_timeout       = r_err_timeout;
endmodule
